// File: rtl/vdp_vram_pkg.sv
// Shared types for the VDP VRAM arbiter: FSM states and requester (owner) encoding.
package vdp_vram_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_CMD = 2'd2
  } owner_e;

  // Bit order {cmd, cpu, vid} matches the per-requester ack/rdata_en vectors.
  function automatic logic [2:0] owner_onehot(input owner_e owner);
    logic [2:0] oh;
    oh = 3'b000;
    case (owner)
      OWN_VID: oh = 3'b001;
      OWN_CPU: oh = 3'b010;
      OWN_CMD: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vdp_vram_arb_grant.sv
// Combinational grant select: video always wins; prefer_cmd_i breaks a CPU/command tie.
module vdp_vram_arb_grant
  import vdp_vram_pkg::*;
(
  input  logic   vid_req_i,
  input  logic   cpu_req_i,
  input  logic   cmd_req_i,
  input  logic   prefer_cmd_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  always_comb begin
    gnt_valid_o = vid_req_i | cpu_req_i | cmd_req_i;
    gnt_owner_o = OWN_VID;
    if (vid_req_i) begin
      gnt_owner_o = OWN_VID;
    end else if (cpu_req_i && !(cmd_req_i && prefer_cmd_i)) begin
      gnt_owner_o = OWN_CPU;
    end else if (cmd_req_i) begin
      gnt_owner_o = OWN_CMD;
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Three-requester VRAM arbiter in front of an SDRAM controller, one access outstanding.
// Define VDP_ARB_RR_EN to round-robin CPU/command; otherwise fixed vid > cpu > cmd.
module vdp_vram_arbiter
  import vdp_vram_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic              cpu_req,
  input  logic              cmd_req,
  input  logic              vid_we,
  input  logic              cpu_we,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              vid_ack,
  output logic              cpu_ack,
  output logic              cmd_ack,
  output logic              vid_rdata_en,
  output logic              cpu_rdata_en,
  output logic              cmd_rdata_en,
  output logic [DATA_W-1:0] rdata,
  output logic              sdr_valid,
  output logic              sdr_write,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [DATA_W-1:0] sdr_wdata,
  input  logic              sdr_ready,
  input  logic [DATA_W-1:0] sdr_rdata,
  input  logic              sdr_rdata_en
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                sdr_write_q, sdr_write_d;
  logic [ADDR_W-1:0]   sdr_addr_q, sdr_addr_d;
  logic [DATA_W-1:0]   sdr_wdata_q, sdr_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          rdata_en_q, rdata_en_d;
  logic                gnt_valid;
  owner_e              gnt_owner;
  logic                prefer_cmd;
  logic                handshake;
  logic [2:0]          ack_vec;
  logic [2:0]          rdata_en_vec;

  assign handshake = (state_q == ISSUE) && sdr_ready && !reset;

`ifdef VDP_ARB_RR_EN
  logic ptr_cmd_q, ptr_cmd_d;

  // Pointer names the requester that wins the next CPU/command tie.
  always_comb begin
    ptr_cmd_d = ptr_cmd_q;
    if (handshake && (owner_q != OWN_VID)) begin
      ptr_cmd_d = (owner_q == OWN_CPU);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_cmd_q <= 1'b0;
    end else begin
      ptr_cmd_q <= ptr_cmd_d;
    end
  end

  assign prefer_cmd = ptr_cmd_q;
`else
  assign prefer_cmd = 1'b0;
`endif

  vdp_vram_arb_grant u_grant (
    .vid_req_i    (vid_req),
    .cpu_req_i    (cpu_req),
    .cmd_req_i    (cmd_req),
    .prefer_cmd_i (prefer_cmd),
    .gnt_valid_o  (gnt_valid),
    .gnt_owner_o  (gnt_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sdr_write_d = sdr_write_q;
    sdr_addr_d  = sdr_addr_q;
    sdr_wdata_d = sdr_wdata_q;
    rdata_d     = rdata_q;
    rdata_en_d  = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ISSUE;
          owner_d = gnt_owner;
          case (gnt_owner)
            OWN_CPU: begin
              sdr_write_d = cpu_we;
              sdr_addr_d  = cpu_addr;
              sdr_wdata_d = cpu_wdata;
            end
            OWN_CMD: begin
              sdr_write_d = cmd_we;
              sdr_addr_d  = cmd_addr;
              sdr_wdata_d = cmd_wdata;
            end
            default: begin
              sdr_write_d = vid_we;
              sdr_addr_d  = vid_addr;
              sdr_wdata_d = vid_wdata;
            end
          endcase
        end
      end
      ISSUE: begin
        if (sdr_ready) begin
          state_d = sdr_write_q ? IDLE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (sdr_rdata_en) begin
          rdata_d    = sdr_rdata;
          rdata_en_d = owner_onehot(owner_q);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_VID;
      sdr_write_q <= 1'b0;
      sdr_addr_q  <= '0;
      sdr_wdata_q <= '0;
      rdata_q     <= '0;
      rdata_en_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      sdr_write_q <= sdr_write_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_wdata_q <= sdr_wdata_d;
      rdata_q     <= rdata_d;
      rdata_en_q  <= rdata_en_d;
    end
  end

  // Strobes are gated by reset so nothing leaks out before the first reset edge.
  assign ack_vec      = owner_onehot(owner_q) & {3{handshake}};
  assign rdata_en_vec = rdata_en_q & {3{!reset}};

  assign vid_ack      = ack_vec[0];
  assign cpu_ack      = ack_vec[1];
  assign cmd_ack      = ack_vec[2];
  assign vid_rdata_en = rdata_en_vec[0];
  assign cpu_rdata_en = rdata_en_vec[1];
  assign cmd_rdata_en = rdata_en_vec[2];
  assign rdata        = rdata_q;
  assign sdr_valid    = (state_q == ISSUE) && !reset;
  assign sdr_write    = sdr_write_q;
  assign sdr_addr     = sdr_addr_q;
  assign sdr_wdata    = sdr_wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Scoreboard bench for vdp_vram_arbiter; honours VDP_ARB_RR_EN for the arbitration order.
module tb_vdp_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]    own;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_r   [3];
  logic          we_r    [3];
  logic [AW-1:0] addr_r  [3];
  logic [DW-1:0] wdata_r [3];
  logic          vid_ack, cpu_ack, cmd_ack;
  logic          vid_rdata_en, cpu_rdata_en, cmd_rdata_en;
  logic [DW-1:0] rdata;
  logic          sdr_valid, sdr_write;
  logic [AW-1:0] sdr_addr;
  logic [DW-1:0] sdr_wdata;
  logic          sdr_ready;
  logic [DW-1:0] sdr_rdata;
  logic          sdr_rdata_en;
  logic [2:0]    ackv, rdenv;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_cnt [3];
  int   rden_total;
  int   rd_lat;
  txn_t pend_q [3][$];
  txn_t exp_q  [3][$];
  rd_t  rd_exp [$];
  int   grant_log [$];

  assign ackv  = {cmd_ack, cpu_ack, vid_ack};
  assign rdenv = {cmd_rdata_en, cpu_rdata_en, vid_rdata_en};

  always #5 clk = ~clk;

  vdp_vram_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vid_req      (req_r[0]),
    .cpu_req      (req_r[1]),
    .cmd_req      (req_r[2]),
    .vid_we       (we_r[0]),
    .cpu_we       (we_r[1]),
    .cmd_we       (we_r[2]),
    .vid_addr     (addr_r[0]),
    .cpu_addr     (addr_r[1]),
    .cmd_addr     (addr_r[2]),
    .vid_wdata    (wdata_r[0]),
    .cpu_wdata    (wdata_r[1]),
    .cmd_wdata    (wdata_r[2]),
    .vid_ack      (vid_ack),
    .cpu_ack      (cpu_ack),
    .cmd_ack      (cmd_ack),
    .vid_rdata_en (vid_rdata_en),
    .cpu_rdata_en (cpu_rdata_en),
    .cmd_rdata_en (cmd_rdata_en),
    .rdata        (rdata),
    .sdr_valid    (sdr_valid),
    .sdr_write    (sdr_write),
    .sdr_addr     (sdr_addr),
    .sdr_wdata    (sdr_wdata),
    .sdr_ready    (sdr_ready),
    .sdr_rdata    (sdr_rdata),
    .sdr_rdata_en (sdr_rdata_en)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM read contents model.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic push_req(input int o, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    txn_t t;
    t.we    = we;
    t.addr  = a;
    t.wdata = d;
    pend_q[o].push_back(t);
    exp_q[o].push_back(t);
  endtask

  task automatic wait_ack(input int o, input int bound, output int cyc);
    cyc = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (ackv[o]) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int bound, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (pend_q[0].size() == 0 && pend_q[1].size() == 0 && pend_q[2].size() == 0 &&
          exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
          rd_exp.size() == 0 && !req_r[0] && !req_r[1] && !req_r[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'(1));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Requester drivers: hold req until ack, then present the next queued access.
  initial begin
    logic [2:0] done;
    txn_t       t;
    for (int g = 0; g < 3; g++) begin
      req_r[g]   = 1'b0;
      we_r[g]    = 1'b0;
      addr_r[g]  = '0;
      wdata_r[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) done[g] = req_r[g] && ackv[g];
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (done[g] || reset) req_r[g] = 1'b0;
        if (!req_r[g] && !reset && pend_q[g].size() > 0) begin
          t          = pend_q[g].pop_front();
          req_r[g]   = 1'b1;
          we_r[g]    = t.we;
          addr_r[g]  = t.addr;
          wdata_r[g] = t.wdata;
        end
      end
    end
  end

  // SDRAM responder: read data returns rd_lat cycles after the read handshake.
  initial begin
    int            cnt;
    logic [AW-1:0] pend_addr;
    cnt          = 0;
    pend_addr    = '0;
    sdr_rdata_en = 1'b0;
    sdr_rdata    = '0;
    forever begin
      @(negedge clk);
      sdr_rdata_en = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sdr_rdata_en = 1'b1;
          sdr_rdata    = rd_fn(pend_addr);
        end
      end
      if (!reset && sdr_valid && sdr_ready && !sdr_write) begin
        cnt       = rd_lat;
        pend_addr = sdr_addr;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic            hs;
    int              o;
    txn_t            e;
    rd_t             r;
    logic            stall_prev;
    logic [AW+DW:0]  stall_val;
    logic            rst_prev;
    stall_prev = 1'b0;
    stall_val  = '0;
    rst_prev   = 1'b0;
    rden_total = 0;
    for (int g = 0; g < 3; g++) ack_cnt[g] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rst_prev) begin
          check("reset_outputs", 64'({ackv, rdenv, sdr_valid, sdr_write, sdr_addr, sdr_wdata,
                                      rdata}), 64'(0));
        end
        for (int g = 0; g < 3; g++) exp_q[g].delete();
        rd_exp.delete();
        stall_prev = 1'b0;
      end else begin
        hs = sdr_valid && sdr_ready;
        if (stall_prev) begin
          check("sdr_stable", 64'({sdr_write, sdr_addr, sdr_wdata}), 64'(stall_val));
        end
        stall_prev = sdr_valid && !sdr_ready;
        stall_val  = {sdr_write, sdr_addr, sdr_wdata};
        if (hs || ackv != 3'b000) begin
          check("ack_with_handshake", 64'({hs, $onehot(ackv)}), 64'(2'b11));
          o = ackv[1] ? 1 : (ackv[2] ? 2 : 0);
          ack_cnt[o]++;
          grant_log.push_back(o);
          if (exp_q[o].size() == 0) begin
            check("ack_unexpected_owner", 64'(o + 1), 64'(0));
          end else begin
            e = exp_q[o].pop_front();
            check("sdr_command", 64'({sdr_write, sdr_addr, sdr_wdata}), 64'(e));
            if (!e.we) begin
              r.own  = 2'(o);
              r.data = rd_fn(e.addr);
              rd_exp.push_back(r);
            end
          end
        end
        if (rdenv != 3'b000) begin
          rden_total++;
          if (rd_exp.size() == 0) begin
            check("rden_unexpected", 64'(rdenv), 64'(0));
          end else begin
            r = rd_exp.pop_front();
            check("rden_owner", 64'(rdenv), 64'(3'(3'b001 << r.own)));
            check("rdata", 64'(rdata), 64'(r.data));
          end
        end
      end
      rst_prev = reset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int cyc, cyc2, n_ack, r0, a0, a1;
    int exp_ord [5];
    reset     = 1'b1;
    sdr_ready = 1'b1;
    rd_lat    = 3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // CPU write with ready high: ack on the second cycle after req is presented.
    @(negedge clk);
    push_req(1, 1'b1, 17'h00000, 8'h5A);
    @(posedge clk);
    #1;
    wait_ack(1, 20, cyc);
    check("cpu_wr_latency", 64'(cyc), 64'(2));
    @(negedge clk);
    check("cpu_wr_back_idle", 64'({sdr_valid, ackv}), 64'(0));

    // Video read, data 3 cycles after handshake, rdata_en one cycle later.
    @(negedge clk);
    push_req(0, 1'b0, 17'h1F000, 8'h00);
    wait_ack(0, 20, cyc);
    check("vid_rd_ack_seen", 64'(cyc > 0), 64'(1));
    cyc2 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdenv[0]) begin
        cyc2 = n;
        break;
      end
    end
    check("vid_rd_latency", 64'(cyc2), 64'(4));
    check("vid_rdata_a5", 64'(rdata), 64'(8'hA5));

    // Controller stall: command held stable, no ack until ready.
    @(posedge clk);
    #1 sdr_ready = 1'b0;
    @(negedge clk);
    push_req(1, 1'b1, 17'h12345, 8'h3C);
    n_ack = 0;
    repeat (12) begin
      @(negedge clk);
      if (ackv != 3'b000) n_ack++;
    end
    check("stall_no_ack", 64'(n_ack), 64'(0));
    check("stall_valid_held", 64'({sdr_valid, sdr_addr}), 64'({1'b1, 17'h12345}));
    @(posedge clk);
    #1 sdr_ready = 1'b1;
    wait_ack(1, 5, cyc);
    check("stall_release", 64'(cyc), 64'(1));

    // Reset while waiting for read data: the late data must be ignored.
    rd_lat = 5;
    @(negedge clk);
    push_req(0, 1'b0, 17'h00100, 8'h00);
    wait_ack(0, 20, cyc);
    check("rst_rd_ack_seen", 64'(cyc > 0), 64'(1));
    do_reset(2);
    r0 = rden_total;
    repeat (10) @(negedge clk);
    check("rst_no_rden", 64'(rden_total), 64'(r0));
    check("rst_rdata_cleared", 64'(rdata), 64'(0));

    // Simultaneous requests from a fresh reset, CPU and command re-requesting.
    rd_lat = 2;
    do_reset(2);
    @(negedge clk);
    grant_log.delete();
    push_req(0, 1'b1, 17'h00010, 8'h11);
    push_req(1, 1'b1, 17'h00020, 8'h21);
    push_req(1, 1'b1, 17'h00021, 8'h22);
    push_req(2, 1'b1, 17'h00030, 8'h31);
    push_req(2, 1'b1, 17'h00031, 8'h32);
    wait_drain(60, "arb_drain");
`ifdef VDP_ARB_RR_EN
    exp_ord = '{0, 1, 2, 1, 2};
`else
    exp_ord = '{0, 1, 1, 2, 2};
`endif
    check("arb_grant_count", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("arb_order", 64'(grant_log[i]), 64'(exp_ord[i]));
    end

    // Long CPU write stream with periodic video reads.
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    r0 = rden_total;
    @(negedge clk);
    for (int i = 0; i < 32768; i++) push_req(1, 1'b1, 17'(i), 8'(i & 8'hFF));
    for (int k = 0; k < 512; k++) begin
      repeat (100) @(negedge clk);
      push_req(0, 1'b0, 17'(k * 37 + 17'h10000), 8'h00);
    end
    wait_drain(20000, "stress_drain");
    check("stress_cpu_acks", 64'(ack_cnt[1] - a1), 64'(32768));
    check("stress_vid_acks", 64'(ack_cnt[0] - a0), 64'(512));
    check("stress_vid_rden", 64'(rden_total - r0), 64'(512));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_vram_arbiter.md
VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, VRAM byte-address width (128 KiB).
REQ-002 SHALL have parameter DATA_W, default 8, VRAM data width.
REQ-003 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vid_req / cpu_req / cmd_req  in  1 each  access request; held until the matching ack.
- vid_we / cpu_we / cmd_we  in  1 each  1 = write, 0 = read.
- vid_addr / cpu_addr / cmd_addr  in  ADDR_W each  byte address.
- vid_wdata / cpu_wdata / cmd_wdata  in  DATA_W each  write data.
- vid_ack / cpu_ack / cmd_ack  out  1 each  one-cycle accept pulse.
- vid_rdata_en / cpu_rdata_en / cmd_rdata_en  out  1 each  one-cycle read-data-valid pulse.
- rdata  out  DATA_W  read data, shared by all requesters.
- sdr_valid  out  1  command valid to the SDRAM controller.
- sdr_write  out  1  1 = write.
- sdr_addr  out  ADDR_W  address.
- sdr_wdata  out  DATA_W  write data.
- sdr_ready  in  1  controller accepts the command when sdr_valid and sdr_ready are both high.
- sdr_rdata  in  DATA_W  read data.
- sdr_rdata_en  in  1  read data valid.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT_DATA.
REQ-005 In IDLE with any req high, SHALL select an owner, register its we/addr/wdata onto sdr_*, and enter ISSUE next cycle with sdr_valid=1.
REQ-006 Arbitration: vid beats all others; the CPU/command order is set by REQ-017/018.
REQ-007 In ISSUE, SHALL hold sdr_valid and all sdr_* stable until sdr_ready=1.
REQ-008 On the handshake cycle, SHALL pulse the owner's ack in that same cycle.
REQ-009 After a write handshake, SHALL go to IDLE; after a read handshake, SHALL go to WAIT_DATA.
REQ-010 In WAIT_DATA, on sdr_rdata_en, SHALL register sdr_rdata to rdata and pulse the owner's rdata_en one cycle later, then go to IDLE.
REQ-011 SHALL keep at most one transaction outstanding; minimum request-to-ack latency is 1 cycle (req sampled at cycle N, ack at N+1 if sdr_ready is high).
REQ-012 SHALL assert sdr_valid=0 in IDLE and WAIT_DATA; SHALL ignore sdr_rdata_en outside WAIT_DATA.
REQ-013 A req dropped before its ack is a requester protocol violation; the arbiter SHALL complete the issued access regardless.
REQ-014 Simultaneous requests SHALL resolve within one IDLE cycle; losers stay pending without any ack.

Reset
REQ-015 While reset=1: state=IDLE; all ack, rdata_en and sdr_valid = 0; sdr_write=0; sdr_addr=0; sdr_wdata=0; rdata=0; RR pointer = CPU.
REQ-016 Reset mid-transaction SHALL abandon the outstanding access; no ack or rdata_en SHALL follow the reset.

Configuration
REQ-017 With VDP_ARB_RR_EN defined: CPU and command SHALL round-robin; the pointer SHALL flip to the other requester after each CPU or command handshake.
REQ-018 Without VDP_ARB_RR_EN: fixed priority vid > cpu > cmd; no pointer register SHALL exist.

Structure
REQ-019 The state enum (IDLE/ISSUE/WAIT_DATA) and owner encoding (OWN_VID/OWN_CPU/OWN_CMD) SHALL live in shared package vdp_vram_pkg.
REQ-020 The grant decision SHALL live in sub-module vdp_vram_arb_grant (combinational priority/RR select); the FSM and datapath stay in the top module.

Verification
REQ-021 Bench SHALL cover these scenarios:
- CPU write addr 0x00000 data 0x5A, sdr_ready=1 -> sdr_valid at cycle 1, cpu_ack same cycle, state returns to IDLE.
- vid read addr 0x1F000, sdr_rdata_en 3 cycles after the handshake with 0xA5 -> rdata=0xA5 and vid_rdata_en pulse the next cycle.
- vid, cpu and cmd requesting together -> vid granted first; then with RR: cpu, cmd; without RR: cpu, cmd (check both builds with cpu/cmd re-requesting: RR alternates, fixed priority starves cmd).
- sdr_ready held low 10 cycles -> sdr_* stable throughout, no ack until ready.
- reset asserted in WAIT_DATA -> outputs cleared, the later sdr_rdata_en is ignored, no rdata_en.
- 32768 sequential CPU writes (data = i & 0xFF) alongside periodic vid reads -> every access acked exactly once and the write sequence is preserved.
